matrix_n_mac_stream: RTL
========================

Name: matrix_n_mac_stream

Overview:
- Parametrised signed fixed-point N×N matrix multiplier, M = A·B (+ previous M in accumulate mode), for the cube/graphics transform pipeline.
- Uses an N×N array of MAC cells. It steps the inner index k over N cycles, then applies one shared round/saturate stage.
- Sits between the transform-matrix source and the vertex transformer. Uses a valid/ready handshake on both sides.
- Output register is decoupled from the datapath, so a new job can run while the previous result waits for the sink.

Parameters:
- N, 4, matrix dimension (≥2).
- DATA_W, 16, element width, signed two's complement.
- FRAC_W, 15, fractional bits used when normalize=1 (Q1.15 at default), 1 ≤ FRAC_W < DATA_W.
- ACC_W, 2*DATA_W+$clog2(N)+1, accumulator width; guarantees no internal overflow.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- input_valid  in  1  A/B/mode are valid.
- sink_ready  out  1  block can accept a job.
- A  in  N×N×DATA_W  left operand, A[row][col].
- B  in  N×N×DATA_W  right operand.
- normalize  in  1  1: result = round(sum >> FRAC_W); 0: raw integer sum.
- accumulate  in  1  1: add the last completed M (pre-scaled) to the new product.
- source_ready  in  1  downstream accepts M.
- output_valid  out  1  M is valid.
- M  out  N×N×DATA_W  saturated result.
- overflow  out  1  at least one element of the current M saturated; valid with output_valid.

Behaviour:
- Reset is asynchronous, active-low: clock and reset are fixed as clk and rst_n. On reset, state=IDLE, sink_ready=1, output_valid=0, M=0, overflow=0, all accumulators, counters and operand registers cleared.
- Reset asserted mid-job aborts the job; no output_valid is produced for it.
- FSM states:
  - IDLE: sink_ready=1. On input_valid, latch A, B, normalize, accumulate; go to RUN, k=0.
  - RUN: one k per cycle. acc[i][j] += sext(A[i][k])*sext(B[k][j]). After k=N-1, go to FIN.
  - FIN: per element, if normalize, add 1<<(FRAC_W-1), then arithmetic shift right by FRAC_W. Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
    - If the output slot is free (output_valid=0, or source_ready=1 this cycle), load M and overflow, set output_valid=1, go to IDLE.
    - Otherwise stay in FIN (stall).
- Handshake:
  - Input transfer happens on an edge where input_valid && sink_ready.
  - Output transfer happens on an edge where output_valid && source_ready.
  - sink_ready depends only on state, never combinationally on input_valid.
- Latency: with an uncongested sink, output_valid rises N+1 edges after the input-transfer edge.
  - Throughput is one job per N+2 cycles.
  - A new job may be accepted while output_valid=1 is unacknowledged.
- Accumulate mode:
  - At input transfer, acc is initialised to sext(M_last), shifted left by FRAC_W if normalize. Otherwise acc is initialised to 0.
  - M_last is the most recently loaded M register value (0 after reset).
- Simultaneous events:
  - An output transfer and a FIN load on the same edge: the new M wins and output_valid stays 1.
  - An output transfer with no load: output_valid→0.
- M and overflow hold stable while output_valid=1 && source_ready=0.
- Rounding is applied once, to the full sum, never per product.

Decomposition:
- Package matrix_pkg holds:
  - default DATA_W, FRAC_W;
  - the function sat_round(acc, normalize) returning data plus an overflow bit;
  - the state enum {IDLE, RUN, FIN}.
- Sub-module mac_cell (one per element): clear/preload, enable, multiply-accumulate, ACC_W-wide register. The top level holds the FSM, k counter, operand registers, finaliser and output register.

Test Plan:
- Identity: normalize=0, A=I (1s), B[i][j]=i*4+j → M=B, overflow=0. output_valid rises exactly 5 edges after acceptance (N=4).
- Sign: normalize=0, A=-I (0xFFFF diag), B all 5 → diagonal-product M[i][j]=0xFFFB.
- Rounding and saturation, normalize=1:
  - A[0][0]=0x0001, B[0][0]=0x4000, rest 0 → M[0][0]=0x0001.
  - Separately, A and B all 0x4000 → every M=0x7FFF, overflow=1.
- Backpressure: source_ready=0 for 20 cycles with two jobs issued.
  - Job 2 is accepted and stalls in FIN with sink_ready=0.
  - M holds job 1 stable.
  - Releasing source_ready delivers job 1 then job 2, with no loss or duplication.
- Accumulate: job 1 normalize=0, A=I, B all 3 → M=3. Job 2 accumulate=1, same operands → M=6. Job 3 accumulate=0 → M=3.
- Reset: assert rst_n=0 during RUN at k=2, then release → sink_ready=1, output_valid=0, M=0. The next job completes correctly.

Source files
------------

// File: rtl/matrix_n_mac_stream_pkg.sv
// Shared types and the round/saturate helper for the N x N matrix MAC stream.
package matrix_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 15;
  // Working width of sat_round; accumulators must stay narrower than this.
  localparam int MAX_W      = 64;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] data;
  } sat_res_t;

  // Round half-up once on the full sum, then clamp to a data_w-bit signed range.
  function automatic sat_res_t sat_round(input logic signed [MAX_W-1:0] acc,
                                         input logic normalize,
                                         input int frac_w,
                                         input int data_w);
    logic signed [MAX_W-1:0] one, v, hi, lo;
    sat_res_t r;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    v   = acc;
    if (normalize) v = (acc + (one <<< (frac_w - 1))) >>> frac_w;
    hi = (one <<< (data_w - 1)) - one;
    lo = -(one <<< (data_w - 1));
    r.ovf  = 1'b0;
    r.data = v;
    if (v > hi) begin
      r.data = hi;
      r.ovf  = 1'b1;
    end else if (v < lo) begin
      r.data = lo;
      r.ovf  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/matrix_n_mac_stream_if.sv
// Job/result stream between the matrix source, the multiplier and the vertex transformer.
interface matrix_n_mac_stream_if
  import matrix_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = DATA_W_DEF
);
  logic                             input_valid;
  logic                             sink_ready;
  logic [N-1:0][N-1:0][DATA_W-1:0]  A;
  logic [N-1:0][N-1:0][DATA_W-1:0]  B;
  logic                             normalize;
  logic                             accumulate;
  logic                             source_ready;
  logic                             output_valid;
  logic [N-1:0][N-1:0][DATA_W-1:0]  M;
  logic                             overflow;

  modport master (
    output input_valid, A, B, normalize, accumulate, source_ready,
    input  sink_ready, output_valid, M, overflow
  );

  modport slave (
    input  input_valid, A, B, normalize, accumulate, source_ready,
    output sink_ready, output_valid, M, overflow
  );
endinterface

// File: rtl/matrix_n_mac_stream_mac_cell.sv
// One result element: preloadable signed multiply-accumulate register.
module mac_cell #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [ACC_W-1:0]  ld_val,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] prod;

  assign prod = $signed(a) * $signed(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= ld_val;
    else if (en)  acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  end
endmodule

// File: rtl/matrix_n_mac_stream.sv
// N x N signed fixed-point matrix multiply (optionally accumulating onto the last result),
// one inner index per cycle, with a result register decoupled from the MAC array.
module matrix_n_mac_stream
  import matrix_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ACC_W  = 2*DATA_W + $clog2(N) + 1
) (
  input logic clk,
  input logic rst_n,
  matrix_n_mac_stream_if.slave s
);
  localparam int KW = $clog2(N);

  state_t                           state;
  logic [KW-1:0]                    k;
  logic [N-1:0][N-1:0][DATA_W-1:0]  a_q, b_q;
  logic                             norm_q;
  logic [N-1:0][N-1:0][DATA_W-1:0]  fin_m;
  logic [N-1:0][N-1:0]              fin_ovf;
  logic                             accept, run_en;

  // sink_ready is registered and high only in IDLE, so accept needs only state.
  assign accept = (state == IDLE) && s.input_valid;
  assign run_en = (state == RUN);

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [ACC_W-1:0] m_ext, pre, acc;
      logic [MAX_W-1:0] sat_full;
      logic             unused_sat_hi;

      assign m_ext = {{(ACC_W-DATA_W){s.M[i][j][DATA_W-1]}}, s.M[i][j]};
      // Accumulate mode seeds the sum with the last result, rescaled to the raw domain.
      assign pre   = !s.accumulate ? '0 : (s.normalize ? (m_ext << FRAC_W) : m_ext);

      mac_cell #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .ld_val (pre),
        .en     (run_en),
        .a      (a_q[i][k]),
        .b      (b_q[k][j]),
        .acc    (acc)
      );

      assign {fin_ovf[i][j], sat_full} =
        sat_round({{(MAX_W-ACC_W){acc[ACC_W-1]}}, acc}, norm_q, FRAC_W, DATA_W);
      assign fin_m[i][j]   = sat_full[DATA_W-1:0];
      assign unused_sat_hi = ^sat_full[MAX_W-1:DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      k              <= '0;
      a_q            <= '0;
      b_q            <= '0;
      norm_q         <= 1'b0;
      s.sink_ready   <= 1'b1;
      s.output_valid <= 1'b0;
      s.M            <= '0;
      s.overflow     <= 1'b0;
    end else begin
      if (s.output_valid && s.source_ready) s.output_valid <= 1'b0;
      case (state)
        IDLE: if (s.input_valid) begin
          a_q          <= s.A;
          b_q          <= s.B;
          norm_q       <= s.normalize;
          k            <= '0;
          s.sink_ready <= 1'b0;
          state        <= RUN;
        end
        RUN: begin
          if (k == KW'(N-1)) state <= FIN;
          else               k     <= k + 1'b1;
        end
        FIN: if (!s.output_valid || s.source_ready) begin
          // A same-edge output transfer is overridden: the new result stays valid.
          s.M            <= fin_m;
          s.overflow     <= |fin_ovf;
          s.output_valid <= 1'b1;
          s.sink_ready   <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          s.sink_ready <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule
